// File: rtl/punjac_uzorka_pkg.sv
// Shared constants and state encoding for the sonar-neuron sample packer.
package punjac_uzorka_pkg;
  localparam int BROJ_UZORAKA  = 60;
  localparam int SIRINA        = 16;
  localparam int VEKTOR_SIRINA = BROJ_UZORAKA * SIRINA;

  typedef enum logic [1:0] {
    PUNJENJE   = 2'd0,
    SMIRIVANJE = 2'd1,
    REZULTAT   = 2'd2
  } stanje_e;
endpackage

// File: rtl/punjac_uzorka.sv
// Packs a frame of samples into the neuron input vector, waits for the neuron
// to settle, captures its output and hands it out over valid/ready.
module punjac_uzorka #(
  parameter int BROJ_UZORAKA  = punjac_uzorka_pkg::BROJ_UZORAKA,
  parameter int SIRINA        = punjac_uzorka_pkg::SIRINA,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  input  logic [SIRINA-1:0]              s_data,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [BROJ_UZORAKA*SIRINA-1:0] uzorak,
  input  logic [SIRINA-1:0]              izlaz_in,
  output logic                           r_valid,
  output logic [SIRINA-1:0]              r_data,
  input  logic                           r_ready,
  output logic                           greska,
  output logic                           busy
);
  import punjac_uzorka_pkg::*;

  localparam logic [5:0] IDX_ZADNJI = 6'(BROJ_UZORAKA - 1);
  localparam logic [3:0] CNT_POC    = 4'(SETTLE_CYCLES - 1);

  stanje_e           state_q;
  logic [5:0]        idx_q;
  logic [3:0]        cnt_q;
  logic              r_valid_q;
  logic [SIRINA-1:0] r_data_q;
  logic              greska_q;
  logic [SIRINA-1:0] lanes_q [BROJ_UZORAKA];
  logic              accept;

  assign s_ready = (state_q == PUNJENJE) && !rst;
  assign accept  = s_valid && s_ready;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign greska  = greska_q;
  assign busy    = (state_q != PUNJENJE) || (idx_q != 6'd0);

  // Lanes only change while filling, so the vector is frozen in every other state.
  for (genvar gi = 0; gi < BROJ_UZORAKA; gi++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lanes_q[gi] <= '0;
      end else if (accept && (idx_q == 6'(gi))) begin
        lanes_q[gi] <= s_data;
      end
    end
    assign uzorak[gi*SIRINA +: SIRINA] = lanes_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PUNJENJE;
      idx_q     <= 6'd0;
      cnt_q     <= 4'd0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      greska_q  <= 1'b0;
    end else begin
      greska_q <= 1'b0;
      case (state_q)
        PUNJENJE: begin
          if (accept) begin
            if (idx_q == IDX_ZADNJI) begin
              // The sample count decides the frame end; a missing last only flags it.
              state_q  <= SMIRIVANJE;
              cnt_q    <= CNT_POC;
              idx_q    <= 6'd0;
              greska_q <= !s_last;
            end else if (s_last) begin
              idx_q    <= 6'd0;
              greska_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        SMIRIVANJE: begin
          if (cnt_q == 4'd0) begin
            r_data_q  <= izlaz_in;
            r_valid_q <= 1'b1;
            state_q   <= REZULTAT;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        REZULTAT: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= PUNJENJE;
          end
        end
        default: state_q <= PUNJENJE;
      endcase
    end
  end
endmodule
